phase_accumulator: RTL and testbench

//  DDS phase accumulator: the upstream stage of the waveform LUTs (triangle/sine/saw).

---
 rtl/fg_pkg.sv | 19 +
 rtl/ftw_shadow_reg.sv | 92 +++++++++
 rtl/phase_accumulator.sv | 86 ++++++++
 tb/tb_phase_accumulator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fg_pkg.sv
// Shared defaults and types for the DDS phase accumulator and its FTW shadow register.
package fg_pkg;

  localparam int unsigned ACC_W_DEF     = 16;
  localparam int unsigned ADDR_W_DEF    = 8;
  localparam logic [31:0] FTW_RESET_DEF = 32'h0000_0100;

  // Byte lanes on the write bus
  localparam int unsigned LANE_W    = 8;
  localparam logic [2:0]  LANE_FTW0 = 3'd0;
  localparam logic [2:0]  LANE_FTW1 = 3'd1;

  typedef logic [ACC_W_DEF-1:0] ftw_t;

  function automatic int unsigned lane_count(input int unsigned acc_w);
    return acc_w / LANE_W;
  endfunction

endpackage

// File: rtl/ftw_shadow_reg.sv
// Byte-lane FTW shadow register with atomic commit to the active FTW and a pending flag.
// With PHASE_OFFSET_EN defined, lane ACC_W/8 also holds a committed phase offset.
module ftw_shadow_reg
  import fg_pkg::*;
#(
  parameter int unsigned ACC_W     = ACC_W_DEF,
`ifdef PHASE_OFFSET_EN
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
`endif
  parameter logic [31:0] FTW_RESET = FTW_RESET_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [2:0]        wr_sel,
  input  logic [7:0]        data_in,
  input  logic              commit,
  output logic [ACC_W-1:0]  ftw_active,
`ifdef PHASE_OFFSET_EN
  output logic [ADDR_W-1:0] offset_active,
`endif
  output logic              pending
);

  localparam int unsigned NumLanes = lane_count(ACC_W);
  localparam logic [ACC_W-1:0] FtwInit = FTW_RESET[ACC_W-1:0];

  logic [ACC_W-1:0] shadow_q, shadow_d;
  logic [ACC_W-1:0] active_q, active_d;
  logic             pending_q, pending_d;
  logic             lane_hit;

`ifdef PHASE_OFFSET_EN
  logic [ADDR_W-1:0] off_shadow_q, off_shadow_d;
  logic [ADDR_W-1:0] off_active_q, off_active_d;
`endif

  always_comb begin
    shadow_d = shadow_q;
    lane_hit = 1'b0;
    for (int i = 0; i < NumLanes; i++) begin
      if (wr_en && (wr_sel == 3'(i))) begin
        shadow_d[i*LANE_W +: LANE_W] = data_in;
        lane_hit                     = 1'b1;
      end
    end
`ifdef PHASE_OFFSET_EN
    off_shadow_d = off_shadow_q;
    if (wr_en && (wr_sel == 3'(NumLanes))) begin
      off_shadow_d = ADDR_W'(data_in);
      lane_hit     = 1'b1;
    end
    off_active_d = commit ? off_shadow_d : off_active_q;
`endif
    // A write in the commit cycle is merged into the committed value
    active_d = commit ? shadow_d : active_q;
    if (commit) begin
      pending_d = 1'b0;
    end else if (lane_hit) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q     <= FtwInit;
      active_q     <= FtwInit;
      pending_q    <= 1'b0;
`ifdef PHASE_OFFSET_EN
      off_shadow_q <= '0;
      off_active_q <= '0;
`endif
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
`ifdef PHASE_OFFSET_EN
      off_shadow_q <= off_shadow_d;
      off_active_q <= off_active_d;
`endif
    end
  end

  assign ftw_active = active_q;
  assign pending    = pending_q;
`ifdef PHASE_OFFSET_EN
  assign offset_active = off_active_q;
`endif

endmodule

// File: rtl/phase_accumulator.sv
// DDS phase accumulator: adds the active FTW each enabled cycle, registers the LUT address
// and overflow pulse. Optional phase offset on the address is enabled by PHASE_OFFSET_EN.
module phase_accumulator
  import fg_pkg::*;
#(
  parameter int unsigned ACC_W     = ACC_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter logic [31:0] FTW_RESET = FTW_RESET_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wr_en,
  input  logic [2:0]        wr_sel,
  input  logic [7:0]        data_in,
  input  logic              commit,
  input  logic              sync,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap,
  output logic              pending
);

  logic [ACC_W-1:0]  ftw_active;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W:0]    sum;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrap_q, wrap_d;

`ifdef PHASE_OFFSET_EN
  logic [ADDR_W-1:0] offset_active;
`endif

  ftw_shadow_reg #(
    .ACC_W         (ACC_W),
`ifdef PHASE_OFFSET_EN
    .ADDR_W        (ADDR_W),
`endif
    .FTW_RESET     (FTW_RESET)
  ) u_ftw_shadow_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_sel        (wr_sel),
    .data_in       (data_in),
    .commit        (commit),
    .ftw_active    (ftw_active),
`ifdef PHASE_OFFSET_EN
    .offset_active (offset_active),
`endif
    .pending       (pending)
  );

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, ftw_active};
    acc_d  = acc_q;
    wrap_d = 1'b0;
    if (sync) begin
      acc_d = '0;
    end else if (ena) begin
      acc_d  = sum[ACC_W-1:0];
      wrap_d = sum[ACC_W];
    end
    // Recomputing from acc_d covers hold, sync and advance uniformly
`ifdef PHASE_OFFSET_EN
    addr_d = acc_d[ACC_W-1 -: ADDR_W] + offset_active;
`else
    addr_d = acc_d[ACC_W-1 -: ADDR_W];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      addr_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      addr_q <= addr_d;
      wrap_q <= wrap_d;
    end
  end

  assign addr = addr_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_phase_accumulator.sv
// Self-checking bench for phase_accumulator (default build, ACC_W=16, ADDR_W=8).
module tb_phase_accumulator;
  import fg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, ena, wr_en, commit, sync;
  logic [2:0] wr_sel;
  logic [7:0] data_in;
  logic [7:0] addr;
  logic       wrap, pending;

  int n_checks = 0;
  int n_pass   = 0;

  phase_accumulator #(
    .ACC_W     (16),
    .ADDR_W    (8),
    .FTW_RESET (32'h0100)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .data_in (data_in),
    .commit  (commit),
    .sync    (sync),
    .addr    (addr),
    .wrap    (wrap),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: phase as a plain integer, FTW applied on commit
  int unsigned m_phase;
  ftw_t        m_ftw, m_shadow;
  bit          m_wrap, m_pend, m_valid = 1'b0;

  always @(posedge clk) begin : model
    longint unsigned nxt;
    ftw_t            old_ftw;
    if (!rst_n) begin
      m_phase  = 0;
      m_wrap   = 1'b0;
      m_pend   = 1'b0;
      m_ftw    = 16'h0100;
      m_shadow = 16'h0100;
      m_valid  = 1'b1;
    end else begin
      old_ftw = m_ftw;
      if (wr_en && wr_sel < 2) begin
        m_shadow = (m_shadow & ~(16'hFF << (8 * wr_sel))) | (16'(data_in) << (8 * wr_sel));
        m_pend   = 1'b1;
      end
      if (commit) begin
        m_ftw  = m_shadow;
        m_pend = 1'b0;
      end
      if (sync) begin
        m_phase = 0;
        m_wrap  = 1'b0;
      end else if (ena) begin
        nxt     = longint'(m_phase) + longint'(old_ftw);
        m_wrap  = (nxt >= 65536);
        m_phase = int'(nxt % 65536);
      end else begin
        m_wrap = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_addr", int'(addr), int'(m_phase / 256));
      chk("model_wrap", int'(wrap), int'(m_wrap));
      chk("model_pending", int'(pending), int'(m_pend));
    end
  end

  task automatic idle();
    wr_en = 1'b0; commit = 1'b0; sync = 1'b0;
  endtask

  int wraps;

  initial begin
    rst_n = 1'b0; ena = 1'b0; wr_en = 1'b0; wr_sel = '0; data_in = '0;
    commit = 1'b0; sync = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_addr", int'(addr), 0);
    chk("reset_wrap", int'(wrap), 0);
    chk("reset_pending", int'(pending), 0);

    // Default FTW 0x0100: address steps by one, single wrap on the 256th update
    rst_n = 1'b1; ena = 1'b1;
    wraps = 0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (wrap) wraps++;
      if (k == 1 || k == 2 || k == 100 || k == 255) chk("t1_addr", int'(addr), k);
    end
    chk("t1_wrap_256", int'(wrap), 1);
    chk("t1_addr_256", int'(addr), 0);
    chk("t1_wrap_count", wraps, 1);

    // Shadow writes without commit leave the step at 1
    wr_en = 1'b1; wr_sel = 3'd0; data_in = 8'h00;
    @(negedge clk);
    wr_sel = 3'd1; data_in = 8'h04;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    chk("t2_addr_nocommit", int'(addr), 3);
    chk("t2_pending", int'(pending), 1);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    chk("t2_commit_edge", int'(addr), 4);
    chk("t2_pending_clr", int'(pending), 0);
    @(negedge clk);
    chk("t2_step4_a", int'(addr), 8);
    @(negedge clk);
    chk("t2_step4_b", int'(addr), 12);

    // sync+commit restart with merged write, then run to 0x7F00
    wr_en = 1'b1; wr_sel = 3'd1; data_in = 8'h01; commit = 1'b1; sync = 1'b1;
    @(negedge clk);
    chk("t3_sync_addr", int'(addr), 0);
    wr_sel = 3'd1; data_in = 8'h02; commit = 1'b0; sync = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
    chk("t3_first", int'(addr), 1);
    repeat (8'h7E) @(negedge clk);
    chk("t3_at_7f", int'(addr), 8'h7F);
    sync = 1'b1; commit = 1'b1;
    @(negedge clk);
    idle();
    chk("t3_restart_addr", int'(addr), 0);
    chk("t3_restart_wrap", int'(wrap), 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("t3_step2", int'(addr), 2 * k);
    end

    // Hold with ena=0, then reset discards uncommitted shadow data
    ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_hold_addr", int'(addr), 6);
      chk("t4_hold_wrap", int'(wrap), 0);
    end
    ena = 1'b1; wr_en = 1'b1; wr_sel = 3'd1; data_in = 8'h05;
    @(negedge clk);
    chk("t4_resume", int'(addr), 8);
    wr_en = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("t4_reset_addr", int'(addr), 0);
    chk("t4_reset_pending", int'(pending), 0);
    rst_n = 1'b1; commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    chk("t4_ftw_default_a", int'(addr), 1);
    @(negedge clk);
    chk("t4_ftw_default_b", int'(addr), 2);

    // Lane 2 has no register in this build
    wr_en = 1'b1; wr_sel = 3'd2; data_in = 8'h40;
    @(negedge clk);
    wr_en = 1'b0;
    chk("t6_lane2_pending", int'(pending), 0);
    chk("t6_lane2_addr", int'(addr), 3);

    // FTW=0xFFFF: near-full-scale step, carry on every update after the first
    wr_en = 1'b1; wr_sel = 3'd0; data_in = 8'hFF;
    @(negedge clk);
    wr_sel = 3'd1; commit = 1'b1; sync = 1'b1;
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("t5_first", int'(addr), 8'hFF);
    chk("t5_first_wrap", int'(wrap), 0);
    @(negedge clk);
    chk("t5_second", int'(addr), 8'hFF);
    chk("t5_second_wrap", int'(wrap), 1);
    for (int k = 0; k < 300; k++) begin
      ena = ($urandom_range(0, 9) != 0);
      @(negedge clk);
    end

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      ena     = ($urandom_range(0, 9) < 8);
      wr_en   = ($urandom_range(0, 9) < 3);
      wr_sel  = 3'($urandom_range(0, 3));
      data_in = 8'($urandom);
      commit  = ($urandom_range(0, 9) == 0);
      sync    = ($urandom_range(0, 29) == 0);
      rst_n   = ($urandom_range(0, 99) != 0);
      @(negedge clk);
    end
    idle();
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
